pipelined_carry_bypass_adder: RTL and testbench



---
 rtl/pipelined_carry_bypass_adder.sv | 172 +++++++++++++++++
 tb/tb_pipelined_carry_bypass_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined add/subtract unit built from carry-bypass groups. The carry chain is cut into
// STAGES registered segments. Operands are skewed on the way in and sums are deskewed on the way out.
module pipelined_carry_bypass_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG     = WIDTH / STAGES;
  localparam int NBLK    = SEG / BLOCK;
  localparam int NSM     = STAGES * (STAGES + 1) / 2;
  localparam int NOP_RAW = STAGES * (STAGES - 1) / 2;
  localparam int NOP     = (NOP_RAW > 0) ? NOP_RAW : 1;

  // Triangular storage: stage st keeps finished sum segments 0..st and pending operand segments st+1..STAGES-1.
  function automatic int sm_idx(input int st, input int sg);
    return st * (st + 1) / 2 + sg;
  endfunction

  function automatic int op_idx(input int st, input int sg);
    return st * (STAGES - 1) - st * (st - 1) / 2 + (sg - st - 1);
  endfunction

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] s;
    logic           c;
    logic           c_blk;
    logic           p;
    logic           p_all;
    s     = '0;
    c     = ci;
    c_blk = 1'b0;
    p     = 1'b0;
    p_all = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      c_blk = c;
      p_all = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        p                = x[blk*BLOCK+i] ^ y[blk*BLOCK+i];
        s[blk*BLOCK+i]   = p ^ c;
        c                = (x[blk*BLOCK+i] & y[blk*BLOCK+i]) | (p & c);
        p_all            = p_all & p;
      end
      // A fully propagating group passes its carry-in straight through.
      c = p_all ? c_blk : c;
    end
    return {c, s};
  endfunction

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic             src_valid_s [STAGES];
  logic [SEG-1:0]   xa_s        [STAGES];
  logic [SEG-1:0]   xb_s        [STAGES];
  logic             xc_s        [STAGES];
  logic [SEG:0]     res_s       [STAGES];

  logic             val_r [STAGES];
  logic             car_r [STAGES];
  logic [SEG-1:0]   sm_r  [NSM];
  logic [SEG-1:0]   opa_r [NOP];
  logic [SEG-1:0]   opb_r [NOP];
  logic             ovf_r;

  assign advance_s = !val_r[STAGES-1] || out_ready;
  assign in_ready  = advance_s;
  assign b_eff_s   = sub ? ~b : b;
  assign c0_s      = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid_s[k] = in_valid;
      assign xa_s[k]        = a[SEG-1:0];
      assign xb_s[k]        = b_eff_s[SEG-1:0];
      assign xc_s[k]        = c0_s;
    end else begin : g_body
      assign src_valid_s[k] = val_r[k-1];
      assign xa_s[k]        = opa_r[op_idx(k-1, k)];
      assign xb_s[k]        = opb_r[op_idx(k-1, k)];
      assign xc_s[k]        = car_r[k-1];
    end

    assign res_s[k] = seg_add(xa_s[k], xb_s[k], xc_s[k]);

    // Stage valid, stage carry-out and this stage's own sum segment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        val_r[k]            <= 1'b0;
        car_r[k]            <= 1'b0;
        sm_r[sm_idx(k, k)]  <= '0;
      end else if (advance_s) begin
        val_r[k] <= src_valid_s[k];
        if (src_valid_s[k]) begin
          car_r[k]           <= res_s[k][SEG];
          sm_r[sm_idx(k, k)] <= res_s[k][SEG-1:0];
        end
      end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_seg
      if (j < k) begin : g_deskew
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sm_r[sm_idx(k, j)] <= '0;
          end else if (advance_s && src_valid_s[k]) begin
            sm_r[sm_idx(k, j)] <= sm_r[sm_idx(k-1, j)];
          end
        end
      end else if (j > k) begin : g_skew
        if (k == 0) begin : g_load
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              opa_r[op_idx(k, j)] <= '0;
              opb_r[op_idx(k, j)] <= '0;
            end else if (advance_s && src_valid_s[k]) begin
              opa_r[op_idx(k, j)] <= a[j*SEG +: SEG];
              opb_r[op_idx(k, j)] <= b_eff_s[j*SEG +: SEG];
            end
          end
        end else begin : g_shift
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              opa_r[op_idx(k, j)] <= '0;
              opb_r[op_idx(k, j)] <= '0;
            end else if (advance_s && src_valid_s[k]) begin
              opa_r[op_idx(k, j)] <= opa_r[op_idx(k-1, j)];
              opb_r[op_idx(k, j)] <= opb_r[op_idx(k-1, j)];
            end
          end
        end
      end
    end
  end

  // Overflow: carry into the MSB (recovered as x^y^s there) xor the final carry-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (advance_s && src_valid_s[STAGES-1]) begin
      ovf_r <= xa_s[STAGES-1][SEG-1] ^ xb_s[STAGES-1][SEG-1] ^
               res_s[STAGES-1][SEG-1] ^ res_s[STAGES-1][SEG];
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < STAGES; j++) begin
      sum[j*SEG +: SEG] = sm_r[sm_idx(STAGES-1, j)];
    end
  end

  assign out_valid = val_r[STAGES-1];
  assign cout      = car_r[STAGES-1];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// Directed bench for pipelined_carry_bypass_adder (WIDTH=32, STAGES=4, BLOCK=4).
// Expected results are hand-computed constants.
module tb_pipelined_carry_bypass_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int n_vec;
  int n_miss;

  logic [31:0] st_a  [8];
  logic [31:0] st_b  [8];
  logic        st_c  [8];
  logic        st_sb [8];
  logic [31:0] st_s  [8];
  logic        st_co [8];
  logic        st_ov [8];

  pipelined_carry_bypass_adder #(.WIDTH(32), .STAGES(4), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    sub      = vs;
  endtask

  task automatic single(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic vs,
                        input logic [31:0] es, input logic ec, input logic eo);
    drive(va, vb, vc, vs);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check({tag, "/early"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "/sum"},   sum, es);
    check({tag, "/cout"},  {31'd0, cout}, {31'd0, ec});
    check({tag, "/ovf"},   {31'd0, ovf},  {31'd0, eo});
    tick();
    check({tag, "/drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    repeat (2) tick();
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/sum",       sum, 32'd0);
    check("rst/cout",      {31'd0, cout}, 32'd0);
    check("rst/ovf",       {31'd0, ovf}, 32'd0);
    check("rst/in_ready",  {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    single("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("neg_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single("add_cin",   32'h0000_000C, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0);
    single("sub_pos",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    single("sub_neg",   32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single("sub_cin_x", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    single("bypass",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back stream.
    st_a[0] = 32'h0000_0000; st_b[0] = 32'h0000_0000; st_c[0] = 1'b1; st_sb[0] = 1'b0;
    st_s[0] = 32'h0000_0001; st_co[0] = 1'b0; st_ov[0] = 1'b0;
    st_a[1] = 32'h0000_0007; st_b[1] = 32'h0000_0003; st_c[1] = 1'b0; st_sb[1] = 1'b0;
    st_s[1] = 32'h0000_000A; st_co[1] = 1'b0; st_ov[1] = 1'b0;
    st_a[2] = 32'hFFFF_FFFC; st_b[2] = 32'hFFFF_FFFA; st_c[2] = 1'b0; st_sb[2] = 1'b0;
    st_s[2] = 32'hFFFF_FFF6; st_co[2] = 1'b1; st_ov[2] = 1'b0;
    st_a[3] = 32'hFFFF_FFF1; st_b[3] = 32'h0000_0014; st_c[3] = 1'b0; st_sb[3] = 1'b0;
    st_s[3] = 32'h0000_0005; st_co[3] = 1'b1; st_ov[3] = 1'b0;
    st_a[4] = 32'h1234_5678; st_b[4] = 32'h1111_1111; st_c[4] = 1'b0; st_sb[4] = 1'b0;
    st_s[4] = 32'h2345_6789; st_co[4] = 1'b0; st_ov[4] = 1'b0;
    st_a[5] = 32'hFFFF_0000; st_b[5] = 32'h0001_0000; st_c[5] = 1'b0; st_sb[5] = 1'b0;
    st_s[5] = 32'h0000_0000; st_co[5] = 1'b1; st_ov[5] = 1'b0;
    st_a[6] = 32'h0000_0064; st_b[6] = 32'h0000_003A; st_c[6] = 1'b0; st_sb[6] = 1'b1;
    st_s[6] = 32'h0000_002A; st_co[6] = 1'b1; st_ov[6] = 1'b0;
    st_a[7] = 32'h0000_FFFF; st_b[7] = 32'h0000_FFFF; st_c[7] = 1'b0; st_sb[7] = 1'b0;
    st_s[7] = 32'h0001_FFFE; st_co[7] = 1'b0; st_ov[7] = 1'b0;

    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 8) begin
        drive(st_a[cyc], st_b[cyc], st_c[cyc], st_sb[cyc]);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (cyc >= 3) begin
        check($sformatf("stream%0d/valid", cyc - 3), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream%0d/sum", cyc - 3),   sum, st_s[cyc-3]);
        check($sformatf("stream%0d/cout", cyc - 3),  {31'd0, cout}, {31'd0, st_co[cyc-3]});
        check($sformatf("stream%0d/ovf", cyc - 3),   {31'd0, ovf},  {31'd0, st_ov[cyc-3]});
      end
    end
    tick();
    check("stream/drain", {31'd0, out_valid}, 32'd0);

    // Fill, stall for three cycles, then drain. Beat n is (n+1)*0x100 + n.
    for (int n = 0; n < 4; n++) begin
      drive(32'h100 * (n + 1), n, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b0;
    drive(32'h0000_0500, 32'h0000_0004, 1'b0, 1'b0);
    #1;
    check("stall/in_ready0", {31'd0, in_ready}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall%0d/in_ready", s), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall%0d/valid", s),    {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d/sum", s),      sum, 32'h0000_0100);
      check($sformatf("stall%0d/cout", s),     {31'd0, cout}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release/in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("release/sum1", sum, 32'h0000_0201);
    check("release/valid1", {31'd0, out_valid}, 32'd1);
    for (int n = 2; n < 5; n++) begin
      tick();
      check($sformatf("release/valid%0d", n), {31'd0, out_valid}, 32'd1);
      check($sformatf("release/sum%0d", n),   sum, 32'h100 * (n + 1) + n);
    end
    tick();
    check("release/drain", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with beats in flight.
    drive(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("prerst/valid", {31'd0, out_valid}, 32'd1);
    check("prerst/sum",   sum, 32'h0000_0033);
    #2;
    rst = 1'b1;
    #1;
    check("arst/valid", {31'd0, out_valid}, 32'd0);
    check("arst/sum",   sum, 32'd0);
    check("arst/cout",  {31'd0, cout}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("postrst%0d/valid", i), {31'd0, out_valid}, 32'd0);
    end
    single("fresh", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
